// File: rtl/skut_pkg.sv
// -----------------------------------------------------------------------------
// skut_pkg
// Shared constants and types for the SKUT frame-buffer ping-pong sequencer.
//   SKUT_FRAME_LEN : bytes per SKUT frame (addresses 0..SKUT_FRAME_LEN-1)
//   SKUT_ADDR_W    : frame buffer address width
//   SKUT_IDLE_BYTE : byte driven to the DAC while no valid frame has been read
//   wstate_e       : writer side state (FILL = accepting bytes, WAIT = bank full)
//   bank_t         : frame buffer bank index (bank 0 / bank 1)
// -----------------------------------------------------------------------------
package skut_pkg;

  localparam int unsigned SKUT_FRAME_LEN = 128;
  localparam int unsigned SKUT_ADDR_W    = 7;
  localparam logic [7:0]  SKUT_IDLE_BYTE = 8'h00;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } wstate_e;

  typedef logic bank_t;

endpackage

// File: rtl/skut_rdsel_pipe.sv
// -----------------------------------------------------------------------------
// skut_rdsel_pipe
// Read-side bank select for a dual-bank buffer with RD_LAT cycles of read
// latency. The bank index and a valid flag are delayed so that they line up
// with the buffer read data, then the selected bank's data (or IDLE_BYTE when
// the delayed valid is low) is registered onto o_data.
// Parameters:
//   RD_LAT    : buffer read latency in clock cycles (1..3)
//   IDLE_BYTE : output byte while the delayed valid flag is low
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset, clears the pipe and o_data
//   i_bank   : bank being read this cycle
//   i_valid  : bank holds a valid frame this cycle
//   i_q0     : bank 0 read data
//   i_q1     : bank 1 read data
//   o_data   : registered selected byte (total latency RD_LAT+1 from the read)
// -----------------------------------------------------------------------------
module skut_rdsel_pipe
  import skut_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter logic [7:0]  IDLE_BYTE = SKUT_IDLE_BYTE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  bank_t      i_bank,
  input  logic       i_valid,
  input  logic [7:0] i_q0,
  input  logic [7:0] i_q1,
  output logic [7:0] o_data
);

  logic [RD_LAT-1:0] r_bank_pipe;
  logic [RD_LAT-1:0] r_valid_pipe;
  logic [7:0]        r_data;
  logic              w_bank_dly;
  logic              w_valid_dly;
  logic [7:0]        w_data_d;

  assign w_bank_dly  = r_bank_pipe[RD_LAT-1];
  assign w_valid_dly = r_valid_pipe[RD_LAT-1];

  always_comb begin
    w_data_d = IDLE_BYTE;
    if (w_valid_dly) begin
      w_data_d = w_bank_dly ? i_q1 : i_q0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank_pipe  <= '0;
      r_valid_pipe <= '0;
      r_data       <= IDLE_BYTE;
    end else begin
      r_bank_pipe[0]  <= i_bank;
      r_valid_pipe[0] <= i_valid;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_bank_pipe[i]  <= r_bank_pipe[i-1];
        r_valid_pipe[i] <= r_valid_pipe[i-1];
      end
      r_data <= w_data_d;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/skut_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// skut_pingpong_ctrl
// Sequencer for the two SKUT frame buffers between the SKUT frame former
// (writer) and the DAC distributor (reader). Owns bank assignment, buffer
// write/read enables, the bank swap at reader frame boundaries and the read
// data mux to the DAC. Reports writer overrun and reader underrun.
//
// Optional feature (macro SKUT_PINGPONG_STATS_EN): adds saturating 16-bit
// event counters ovr_cnt / udr_cnt, cleared on reset.
//
// Ports:
//   clk        : system clock (clk80 domain)
//   reset_n    : asynchronous active-low reset
//   wr_en      : writer byte strobe
//   wr_addr    : writer byte address
//   rd_sync    : one-cycle pulse, reader frame start
//   rd_en      : reader fetching a byte this cycle
//   buf0_wren  : bank 0 write enable      buf1_wren : bank 1 write enable
//   buf0_rden  : bank 0 read enable       buf1_rden : bank 1 read enable
//   buf0_q     : bank 0 read data         buf1_q    : bank 1 read data
//   dac_data   : byte to DAC (RD_LAT+1 cycles after rd_en)
//   rd_bank    : bank currently being read
//   overrun    : one-cycle pulse, writer frame dropped because no bank was free
//   underrun   : one-cycle pulse, rd_sync with no new full frame (frame replayed)
//   ovr_cnt    : overrun count  (SKUT_PINGPONG_STATS_EN only)
//   udr_cnt    : underrun count (SKUT_PINGPONG_STATS_EN only)
// -----------------------------------------------------------------------------
module skut_pingpong_ctrl
  import skut_pkg::*;
#(
  parameter int unsigned FRAME_LEN = SKUT_FRAME_LEN,
  parameter int unsigned ADDR_W    = SKUT_ADDR_W,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [7:0]  IDLE_BYTE = SKUT_IDLE_BYTE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_sync,
  input  logic              rd_en,
  output logic              buf0_wren,
  output logic              buf1_wren,
  output logic              buf0_rden,
  output logic              buf1_rden,
  input  logic [7:0]        buf0_q,
  input  logic [7:0]        buf1_q,
  output logic [7:0]        dac_data,
  output logic              rd_bank,
  output logic              overrun,
  output logic              underrun
`ifdef SKUT_PINGPONG_STATS_EN
  ,
  output logic [15:0]       ovr_cnt,
  output logic [15:0]       udr_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_LEN - 1);

  wstate_e r_wstate;
  bank_t   r_wr_bank;
  bank_t   r_rd_bank;
  logic    r_rd_valid;
  logic    r_aligned;   // writer is inside a frame that started at address 0
  logic    r_ovr_seen;  // overrun already reported for the current WAIT period
  logic    r_overrun;
  logic    r_underrun;

  logic w_fill;
  logic w_addr0;
  logic w_wr_ok;
  logic w_frame_done;
  logic w_swap;
  logic w_underrun;
  logic w_overrun;

  assign w_fill  = (r_wstate == FILL);
  assign w_addr0 = (wr_addr == '0);

  // A byte is accepted only while filling, and only once the writer has been
  // seen at address 0 since reset, the last frame end, or the last swap.
  assign w_wr_ok      = wr_en & w_fill & (r_aligned | w_addr0);
  assign w_frame_done = w_wr_ok & (wr_addr == LastAddr);

  // Swap when a full frame is waiting, or when it completes in this very
  // cycle: the last byte still lands in the old write bank.
  assign w_swap     = rd_sync & (~w_fill | w_frame_done);
  assign w_underrun = rd_sync & ~w_swap & r_rd_valid;
  assign w_overrun  = wr_en & ~w_fill & w_addr0 & ~r_ovr_seen;

  assign buf0_wren = w_wr_ok & (r_wr_bank == 1'b0);
  assign buf1_wren = w_wr_ok & (r_wr_bank == 1'b1);
  assign buf0_rden = rd_en & (r_rd_bank == 1'b0);
  assign buf1_rden = rd_en & (r_rd_bank == 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wstate   <= FILL;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b1;
      r_rd_valid <= 1'b0;
      r_aligned  <= 1'b0;
      r_ovr_seen <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_overrun  <= w_overrun;
      r_underrun <= w_underrun;
      if (w_swap) begin
        r_rd_bank  <= r_wr_bank;
        r_wr_bank  <= r_rd_bank;
        r_wstate   <= FILL;
        r_rd_valid <= 1'b1;
        // The writer may be mid-frame; wait for its next address 0.
        r_aligned  <= 1'b0;
        r_ovr_seen <= 1'b0;
      end else begin
        if (w_frame_done) begin
          r_wstate  <= WAIT;
          r_aligned <= 1'b0;
        end else if (w_wr_ok) begin
          r_aligned <= 1'b1;
        end
        if (w_overrun) begin
          r_ovr_seen <= 1'b1;
        end
      end
    end
  end

  assign rd_bank  = r_rd_bank;
  assign overrun  = r_overrun;
  assign underrun = r_underrun;

  skut_rdsel_pipe #(
    .RD_LAT    (RD_LAT),
    .IDLE_BYTE (IDLE_BYTE)
  ) u_rdsel_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_bank  (r_rd_bank),
    .i_valid (r_rd_valid),
    .i_q0    (buf0_q),
    .i_q1    (buf1_q),
    .o_data  (dac_data)
  );

`ifdef SKUT_PINGPONG_STATS_EN
  logic [15:0] r_ovr_cnt;
  logic [15:0] r_udr_cnt;

  // Counters advance on the same edge that raises the matching pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr_cnt <= '0;
      r_udr_cnt <= '0;
    end else begin
      if (w_overrun && (r_ovr_cnt != 16'hFFFF)) begin
        r_ovr_cnt <= r_ovr_cnt + 16'd1;
      end
      if (w_underrun && (r_udr_cnt != 16'hFFFF)) begin
        r_udr_cnt <= r_udr_cnt + 16'd1;
      end
    end
  end

  assign ovr_cnt = r_ovr_cnt;
  assign udr_cnt = r_udr_cnt;
`endif

endmodule
